// File: rtl/data_split_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_split_pkg
// Brief   : Shared state encoding and sample width for the data_split slice.
// Revision: 1.0
// ============================================================================
package data_split_pkg;
    localparam int c_SAMPLE_W = 16;
    localparam int c_NUM_BUF  = 3;

    typedef logic [1:0] state_t;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FILL  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
endpackage
`default_nettype wire

// File: rtl/data_split_if.sv
`default_nettype none
// ============================================================================
// Module  : data_split_if
// Brief   : Serial sample input and four-lane parallel output bundle.
// Revision: 1.0
// ============================================================================
interface data_split_if
    import data_split_pkg::*;
#(
    parameter int ADDR_W = 9
);
    logic                  start_in;
    logic                  din_valid;
    logic [c_SAMPLE_W-1:0] din;
    logic                  en_sync_out;
    logic [ADDR_W-1:0]     cnt_sync_out;
    logic [c_SAMPLE_W-1:0] para_out0;
    logic [c_SAMPLE_W-1:0] para_out1;
    logic [c_SAMPLE_W-1:0] para_out2;
    logic [c_SAMPLE_W-1:0] para_out3;
    logic                  frame_done;
    logic                  frame_err;

    modport master (
        output start_in, din_valid, din,
        input  en_sync_out, cnt_sync_out, para_out0, para_out1, para_out2,
        input  para_out3, frame_done, frame_err
    );

    modport slave (
        input  start_in, din_valid, din,
        output en_sync_out, cnt_sync_out, para_out0, para_out1, para_out2,
        output para_out3, frame_done, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/data_split_ram.sv
`default_nettype none
// ============================================================================
// Module  : split_ram
// Brief   : Simple dual-port lane buffer, registered read with read enable.
// Revision: 1.0
// ============================================================================
module split_ram #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              we_i,
    input  wire logic [ADDR_W-1:0] waddr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic              re_i,
    input  wire logic [ADDR_W-1:0] raddr_i,
    output logic      [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is cleared; array contents stay unknown after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/data_split.sv
`default_nettype none
// ============================================================================
// Module  : data_split
// Brief   : Serial four-lane frame to time-aligned parallel lane words.
// Revision: 1.0
// ============================================================================
module data_split
    import data_split_pkg::*;
#(
    parameter int FFT_POINT = 512,
    parameter int ADDR_W    = 9
) (
    input  wire logic   clk,
    input  wire logic   rst,
    data_split_if.slave bus
);
    localparam int                CNT_W       = ADDR_W + 2;
    localparam logic [CNT_W-1:0]  c_FILL_LAST = CNT_W'(3 * FFT_POINT - 1);
    localparam logic [CNT_W-1:0]  c_FRM_LAST  = CNT_W'(4 * FFT_POINT - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX  = ADDR_W'(FFT_POINT - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  en_q, done_q, err_q, err_d;
    logic [ADDR_W-1:0]     cnt_sync_q;
    logic [c_SAMPLE_W-1:0] para3_q;

    logic [1:0]            w_lane;
    logic [ADDR_W-1:0]     w_addr;
    logic [ADDR_W-1:0]     w_waddr;
    logic [2:0]            w_we;
    logic                  w_rd;
    logic                  w_last;
    logic [c_SAMPLE_W-1:0] w_rdata [c_NUM_BUF];

    assign w_lane = cnt_q[CNT_W-1 -: 2];
    assign w_addr = cnt_q[ADDR_W-1:0];
    assign w_last = (cnt_q == c_FRM_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        w_we    = 3'b000;
        w_rd    = 1'b0;
        w_waddr = w_addr;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.din_valid && bus.start_in) begin
                    w_we[0] = 1'b1;
                    w_waddr = '0;
                    cnt_d   = CNT_W'(1);
                    state_d = c_ST_FILL;
                end
            end
            c_ST_FILL, c_ST_DRAIN: begin
                if (bus.din_valid) begin
                    if (bus.start_in && !w_last) begin
                        err_d   = 1'b1;
                        w_we[0] = 1'b1;
                        w_waddr = '0;
                        cnt_d   = CNT_W'(1);
                        state_d = c_ST_FILL;
                    end else begin
                        case (w_lane)
                            2'd0:    w_we[0] = 1'b1;
                            2'd1:    w_we[1] = 1'b1;
                            2'd2:    w_we[2] = 1'b1;
                            default: w_rd    = 1'b1;
                        endcase
                        if (w_last) begin
                            // A start on the final sample doubles as the next frame's lane0 word 0.
                            if (bus.start_in) begin
                                w_we[0] = 1'b1;
                                w_waddr = '0;
                                cnt_d   = CNT_W'(1);
                                state_d = c_ST_FILL;
                            end else begin
                                cnt_d   = '0;
                                state_d = c_ST_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_q == c_FILL_LAST) begin
                                state_d = c_ST_DRAIN;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_ST_IDLE;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_sync_q <= '0;
            para3_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= w_rd;
            done_q  <= w_rd && (w_addr == c_ADDR_MAX);
            err_q   <= err_d;
            if (w_rd) begin
                cnt_sync_q <= w_addr;
                para3_q    <= bus.din;
            end
        end
    end

    for (genvar gi = 0; gi < c_NUM_BUF; gi++) begin : g_ram
        split_ram #(
            .DEPTH  (FFT_POINT),
            .ADDR_W (ADDR_W),
            .DATA_W (c_SAMPLE_W)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .we_i    (w_we[gi]),
            .waddr_i (w_waddr),
            .wdata_i (bus.din),
            .re_i    (w_rd),
            .raddr_i (w_addr),
            .rdata_o (w_rdata[gi])
        );
    end

    assign bus.en_sync_out  = en_q;
    assign bus.cnt_sync_out = cnt_sync_q;
    assign bus.para_out0    = w_rdata[0];
    assign bus.para_out1    = w_rdata[1];
    assign bus.para_out2    = w_rdata[2];
    assign bus.para_out3    = para3_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_err    = err_q;
endmodule
`default_nettype wire

// File: tb/tb_data_split.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_split
// Brief   : Randomised and directed bench for data_split against a frame model.
// Revision: 1.0
// ============================================================================
module tb_data_split;
    import data_split_pkg::*;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int FR = 4 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_split_if #(.ADDR_W(AW)) bus ();

    data_split #(
        .FFT_POINT (N),
        .ADDR_W    (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: index of the next transfer in the frame (-1 when idle) and the captured samples.
    int          nxt = -1;
    logic [15:0] smp [FR];
    logic        exp_en, exp_done, exp_err;
    logic [31:0] exp_cnt;
    logic [15:0] exp_p [4];

    int n_checks = 0;
    int n_pass   = 0;
    int en_seen, done_seen, err_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_update(input logic r, input logic s_in, input logic v, input logic [15:0] d);
        bit abort;
        int a;
        if (r) begin
            nxt = -1; exp_en = 0; exp_cnt = 0; exp_done = 0; exp_err = 0;
            for (int i = 0; i < 4; i++) exp_p[i] = '0;
        end else begin
            exp_en = 0; exp_done = 0; exp_err = 0;
            if (v) begin
                abort = s_in && (nxt >= 0) && (nxt != FR - 1);
                if (abort) exp_err = 1;
                if (!abort && nxt >= 3 * N) begin
                    a        = nxt - 3 * N;
                    exp_en   = 1;
                    exp_cnt  = a;
                    exp_p[0] = smp[a];
                    exp_p[1] = smp[N + a];
                    exp_p[2] = smp[2 * N + a];
                    exp_p[3] = d;
                    exp_done = (a == N - 1);
                end
                if (s_in) begin
                    smp[0] = d;
                    nxt    = 1;
                end else if (nxt >= 0) begin
                    if (nxt < 3 * N) smp[nxt] = d;
                    nxt = (nxt == FR - 1) ? -1 : nxt + 1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic s_in, input logic v, input logic [15:0] d);
        @(negedge clk);
        rst           = r;
        bus.start_in  = s_in;
        bus.din_valid = v;
        bus.din       = d;
        model_update(r, s_in, v, d);
        @(posedge clk);
        #1;
        check("en_sync_out",  32'(bus.en_sync_out),  32'(exp_en));
        check("cnt_sync_out", 32'(bus.cnt_sync_out), exp_cnt);
        check("para_out0",    32'(bus.para_out0),    32'(exp_p[0]));
        check("para_out1",    32'(bus.para_out1),    32'(exp_p[1]));
        check("para_out2",    32'(bus.para_out2),    32'(exp_p[2]));
        check("para_out3",    32'(bus.para_out3),    32'(exp_p[3]));
        check("frame_done",   32'(bus.frame_done),   32'(exp_done));
        check("frame_err",    32'(bus.frame_err),    32'(exp_err));
        en_seen   += int'(bus.en_sync_out);
        done_seen += int'(bus.frame_done);
        err_seen  += int'(bus.frame_err);
    endtask

    task automatic clr_seen();
        en_seen = 0; done_seen = 0; err_seen = 0;
    endtask

    task automatic send_frame(input int base, input bit gap);
        for (int k = 0; k < FR; k++) begin
            step(1'b0, k == 0, 1'b1, 16'(base + k));
            if (gap) step(1'b0, 1'b0, 1'b0, 16'hdead);
        end
    endtask

    initial begin
        bus.start_in  = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        clr_seen();

        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h1234);

        // Contiguous frame, then the same frame with a one-cycle gap after every sample.
        clr_seen();
        send_frame(0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        check("f1_words", 32'(en_seen), 32'd8);
        check("f1_done",  32'(done_seen), 32'd1);
        clr_seen();
        send_frame(0, 1'b1);
        check("gap_words", 32'(en_seen), 32'd8);

        // Back-to-back frames with no idle cycle between them.
        clr_seen();
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        check("b2b_words", 32'(en_seen), 32'd16);
        check("b2b_done",  32'(done_seen), 32'd2);

        // Start on the final sample: last word still emitted and a new frame begins.
        clr_seen();
        for (int k = 0; k < FR; k++) step(1'b0, (k == 0) || (k == FR - 1), 1'b1, 16'(300 + k));
        for (int k = 1; k < FR; k++) step(1'b0, 1'b0, 1'b1, 16'(400 + k));
        step(1'b0, 1'b0, 1'b0, 16'h0);
        check("slast_words", 32'(en_seen), 32'd16);
        check("slast_err",   32'(err_seen), 32'd0);

        // Restart at transfer 13 of a frame.
        clr_seen();
        for (int k = 0; k < 13; k++) step(1'b0, k == 0, 1'b1, 16'(500 + k));
        send_frame(600, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        check("abort_err",   32'(err_seen), 32'd1);
        check("abort_words", 32'(en_seen), 32'd8);

        // Reset on the drain transfer for address 4, then stray non-start samples.
        clr_seen();
        for (int k = 0; k < 28; k++) step(1'b0, k == 0, 1'b1, 16'(700 + k));
        step(1'b1, 1'b0, 1'b1, 16'(728));
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, 16'(729 + k));
        check("rst_words", 32'(en_seen), 32'd4);
        check("rst_err",   32'(err_seen), 32'd0);

        // Idle garbage followed by a clean frame.
        clr_seen();
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1, 16'($urandom));
        check("idle_quiet", 32'(en_seen), 32'd0);
        send_frame(800, 1'b0);
        check("idle_next_words", 32'(en_seen), 32'd8);

        // Random traffic: gaps, occasional restarts and starts on arbitrary samples.
        for (int c = 0; c < 600; c++) begin
            logic v, s;
            v = ($urandom_range(0, 9) < 7);
            s = (nxt < 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            if (nxt == FR - 1 && $urandom_range(0, 1) == 1) s = 1'b1;
            step(($urandom_range(0, 299) == 0), s, v, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/data_split.md
DATA_SPLIT -- requirements
Module: data_split

Interface
REQ-001 Parameter FFT_POINT, default 512, is the samples per lane per frame; it SHALL be a power of two, 8..4096.
REQ-002 Parameter ADDR_W, default 9, is the lane address width and SHALL equal log2(FFT_POINT).
REQ-003 clk  input  1  rising-edge clock for all logic.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start_in  input  1  frame-start flag, qualified by din_valid, marking the first serial sample.
REQ-006 din_valid  input  1  serial sample qualifier.
REQ-007 din  input  16  serial sample; one frame is lane0, lane1, lane2, lane3 blocks of FFT_POINT samples each.
REQ-008 en_sync_out  output  1  parallel-word valid.
REQ-009 cnt_sync_out  output  ADDR_W  index of the parallel word within the frame.
REQ-010 para_out0..para_out3  output  16 each  time-aligned lane samples.
REQ-011 frame_done  output  1  one-cycle pulse with the last parallel word.
REQ-012 frame_err  output  1  one-cycle pulse on an aborted frame.

Function
REQ-013 States: IDLE, FILL, DRAIN; a transfer is din_valid=1 on a clk edge.
REQ-014 IDLE: a transfer with start_in=0 SHALL be discarded; a transfer with start_in=1 SHALL be written as lane0 address 0 and move to FILL.
REQ-015 Input counter cnt_in, width ADDR_W+2, SHALL count transfers from 0 at frame start; the upper 2 bits select the lane, the lower ADDR_W bits the address.
REQ-016 FILL: transfers with lane 0..2 SHALL be written to buffers 0..2 at the lower-bit address; on the transfer with cnt_in = 3*FFT_POINT-1 the state SHALL become DRAIN.
REQ-017 DRAIN: each lane3 transfer at address a SHALL read buffers 0..2 at address a and delay din by one cycle.
REQ-018 Latency: one cycle after the DRAIN transfer at address a, para_out0..2 SHALL hold buffer data at a, para_out3 SHALL hold that din, cnt_sync_out=a and en_sync_out=1, for exactly one cycle.
REQ-019 Gaps in din_valid SHALL stall cnt_in; en_sync_out SHALL be 0 in the cycles after non-transfers; outputs SHALL stay unchanged while en_sync_out=0.
REQ-020 The transfer at cnt_in = 4*FFT_POINT-1 SHALL return the state to IDLE. frame_done SHALL pulse in the same cycle as the en_sync_out for a = FFT_POINT-1.
REQ-021 A transfer with start_in=1 in FILL or DRAIN SHALL pulse frame_err the next cycle, discard the partial frame with no further en_sync_out from it, and restart as lane0 address 0 in FILL.
REQ-022 A transfer with start_in=1 on the last transfer of a frame SHALL count as a new frame start, not an error; the last parallel word SHALL still be emitted.
REQ-023 Back-to-back frames with zero idle cycles SHALL be supported. A new frame's lane0 writes SHALL NOT corrupt the previous frame's DRAIN reads; reads finish before the new frame writes.
REQ-024 Buffer contents are don't-care after reset; no output may depend on unwritten entries.

Reset
REQ-025 When rst=1, the next cycle SHALL give state IDLE, cnt_in=0, en_sync_out=0, cnt_sync_out=0, para_out0..3=0, frame_done=0, frame_err=0.
REQ-026 rst mid-frame SHALL abandon the frame with no frame_err; the first post-reset frame SHALL behave identically to the first frame after power-up.
REQ-027 rst SHALL take priority over all other inputs, including start_in.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, FILL, DRAIN) and the sample width constant (16).
REQ-029 One sub-module split_ram SHALL be instantiated three times: simple dual-port, FFT_POINT x 16, synchronous write, registered read with 1-cycle latency and read enable.
REQ-030 Outside split_ram, the block SHALL contain only the FSM, counters and output registers; no handshake to upstream exists.

Verification
REQ-031 FFT_POINT=8. One frame din=0..31 contiguous, start with 0 -> 8 en_sync_out pulses; word a gives outputs (a, 8+a, 16+a, 24+a) and cnt_sync_out=a. frame_done with a=7.
REQ-032 Same frame with din_valid toggling 1,0 -> identical parallel words; en_sync_out spaced two cycles apart.
REQ-033 Two back-to-back frames, the second with din=100..131 -> 16 words total; the second frame's word 0 is (100,108,116,124); no corruption.
REQ-034 start_in asserted again at transfer 13 of a frame -> frame_err pulse; no en_sync_out from the aborted frame; the restarted frame output is correct.
REQ-035 rst asserted for one cycle during DRAIN at a=4 -> all outputs 0 next cycle; no further en_sync_out; no frame_err.
REQ-036 din_valid=1 with start_in=0 while IDLE for 20 cycles -> no output activity; the next started frame is correct.
